// File: rtl/interval_timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interval_timer_ctrl_pkg
// Description : Shared types and default widths for the interval timer
//               controller (state encoding, default parameter values).
// Revision    : 1.0 - initial release
// ============================================================================
package interval_timer_ctrl_pkg;

    // Default width of the main count and of the terminal limit
    localparam int C_BUS_WIDTH   = 4;
    // Default width of the prescaler compare value
    localparam int C_PRESC_WIDTH = 4;

    // Controller sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

endpackage : interval_timer_ctrl_pkg
`default_nettype wire

// File: rtl/interval_timer_ctrl_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running 0..i_cmp counter. o_tick is high in the cycle
//               the counter equals i_cmp; when enabled the counter then
//               returns to 0. i_clr forces 0, i_en=0 holds the value.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int PRESC_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clr,
    input  logic                   i_en,
    input  logic [PRESC_WIDTH-1:0] i_cmp,
    output logic                   o_tick
);

    logic [PRESC_WIDTH-1:0] r_cnt;

    assign o_tick = (r_cnt == i_cmp);

    // Count up to the compare value and wrap; clear wins over enable
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (o_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/interval_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : interval_timer_ctrl
// Description : Programmable interval timer sequencer. Start/stop/pause
//               control, prescaled tick, inclusive terminal count, one-shot
//               or periodic operation, registered one-cycle done pulse.
//               Optional sticky interrupt: INTERVAL_TIMER_CTRL_IRQ_STICKY_EN
//               (undefined: irq tied to 0, irq_clr unused).
// Revision    : 1.0 - initial release
// ============================================================================
module interval_timer_ctrl
    import interval_timer_ctrl_pkg::*;
#(
    parameter int BUS_WIDTH   = C_BUS_WIDTH,
    parameter int PRESC_WIDTH = C_PRESC_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   periodic,
    input  logic [BUS_WIDTH-1:0]   limit,
    input  logic [PRESC_WIDTH-1:0] presc,
    input  logic                   irq_clr,
    output logic [BUS_WIDTH-1:0]   count,
    output logic                   busy,
    output logic                   done,
    output logic                   irq
);

    state_t                 r_state;
    logic [BUS_WIDTH-1:0]   r_count;
    logic [BUS_WIDTH-1:0]   r_limit_l;
    logic [PRESC_WIDTH-1:0] r_presc_l;
    logic                   r_periodic_l;
    logic                   r_done;

    logic w_start_go;
    logic w_abort;
    logic w_run_en;
    logic w_presc_tick;
    logic w_tick;
    logic w_terminal;

    // Accepted start from IDLE, and abort from PAUSE (stop beats start)
    assign w_start_go = (r_state == IDLE)  && start && !stop;
    assign w_abort    = (r_state == PAUSE) && stop;
    // Prescaler only advances while running and not being paused this cycle
    assign w_run_en   = (r_state == RUN) && !stop;
    assign w_tick     = w_run_en && w_presc_tick;
    assign w_terminal = w_tick && (r_count == r_limit_l);

    tick_prescaler #(
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_start_go || w_abort),
        .i_en   (w_run_en),
        .i_cmp  (r_presc_l),
        .o_tick (w_presc_tick)
    );

    // Sequencer: state, main count, latched configuration and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_limit_l    <= '0;
            r_presc_l    <= '0;
            r_periodic_l <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_go) begin
                        r_limit_l    <= limit;
                        r_presc_l    <= presc;
                        r_periodic_l <= periodic;
                        r_count      <= '0;
                        r_state      <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        r_state <= PAUSE;
                    end else if (w_terminal) begin
                        r_count <= '0;
                        r_done  <= 1'b1;
                        if (!r_periodic_l) begin
                            r_state <= IDLE;
                        end
                    end else if (w_tick) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                PAUSE: begin
                    if (stop) begin
                        r_count <= '0;
                        r_state <= IDLE;
                    end else if (start) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign count = r_count;
    assign busy  = (r_state != IDLE);
    assign done  = r_done;

`ifdef INTERVAL_TIMER_CTRL_IRQ_STICKY_EN
    logic r_irq;

    // Sticky interrupt: set by a terminal event, cleared by irq_clr; set wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else if (w_terminal) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`else
    logic w_unused_irq_clr;

    assign w_unused_irq_clr = irq_clr;
    assign irq              = 1'b0;
`endif

endmodule : interval_timer_ctrl
`default_nettype wire

// File: tb/tb_interval_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_interval_timer_ctrl
// Description : Self-checking bench for interval_timer_ctrl. A reference
//               model tracks elapsed running clocks and derives count/done
//               arithmetically; directed sequences pin cycle-exact values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interval_timer_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       periodic;
    logic [3:0] limit;
    logic [3:0] presc;
    logic       irq_clr;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       irq;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef INTERVAL_TIMER_CTRL_IRQ_STICKY_EN
    localparam bit c_irq_en = 1'b1;
`else
    localparam bit c_irq_en = 1'b0;
`endif

    interval_timer_ctrl #(
        .BUS_WIDTH   (4),
        .PRESC_WIDTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .periodic (periodic),
        .limit    (limit),
        .presc    (presc),
        .irq_clr  (irq_clr),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .irq      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0=idle 1=run 2=pause; count derived from elapsed clocks
    int m_mode, m_el, m_lim, m_pre;
    bit m_per, m_done, m_irq;
    int e_count;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_el = 0; m_lim = 0; m_pre = 0;
            m_per = 0; m_done = 0; m_irq = 0;
        end else begin
            m_done = 0;
            case (m_mode)
                0: begin
                    if (start && !stop) begin
                        m_mode = 1; m_el = 0;
                        m_lim = int'(limit); m_pre = int'(presc); m_per = periodic;
                    end
                end
                1: begin
                    if (stop) begin
                        m_mode = 2;
                    end else if ((m_el + 1) % ((m_pre + 1) * (m_lim + 1)) == 0) begin
                        m_done = 1;
                        m_el = 0;
                        if (!m_per) m_mode = 0;
                    end else begin
                        m_el++;
                    end
                end
                default: begin
                    if (stop) begin
                        m_mode = 0; m_el = 0;
                    end else if (start) begin
                        m_mode = 1;
                    end
                end
            endcase
            if (c_irq_en) begin
                if (m_done) m_irq = 1;
                else if (irq_clr) m_irq = 0;
            end
        end
        e_count = (m_mode == 0) ? 0 : (m_el / (m_pre + 1)) % (m_lim + 1);
        #2;
        check("model_count", 32'(count), 32'(e_count));
        check("model_busy",  32'(busy),  32'(m_mode != 0));
        check("model_done",  32'(done),  32'(m_done));
        check("model_irq",   32'(irq),   32'(m_irq));
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1; start = 0; stop = 0; periodic = 0; limit = 0; presc = 0; irq_clr = 0;
        repeat (2) cyc();
        check("rst_count", 32'(count), 0);
        check("rst_busy",  32'(busy),  0);
        check("rst_done",  32'(done),  0);
        check("rst_irq",   32'(irq),   0);
        rst = 0;
        cyc();

        // One-shot limit=3 presc=0: count 0..3 in cycles 1..4, done at 5
        limit = 4'd3; presc = 4'd0; periodic = 0; start = 1;
        cyc(); start = 0;
        for (int k = 1; k <= 4; k++) begin
            check("os_count", 32'(count), 32'(k - 1));
            check("os_busy",  32'(busy),  1);
            check("os_done",  32'(done),  0);
            cyc();
        end
        check("os_done5",  32'(done),  1);
        check("os_count5", 32'(count), 0);
        check("os_busy5",  32'(busy),  0);
        cyc();
        check("os_done6",  32'(done),  0);
        check("os_busy6",  32'(busy),  0);

        // Periodic limit=2 presc=2: done at cycles 10, 19, 28
        limit = 4'd2; presc = 4'd2; periodic = 1; start = 1;
        cyc(); start = 0;
        for (int c = 1; c <= 30; c++) begin
            check("per_done", 32'(done), 32'(c == 10 || c == 19 || c == 28));
            check("per_busy", 32'(busy), 1);
            cyc();
        end
        stop = 1; cyc(); cyc(); stop = 0;
        check("per_abort_busy",  32'(busy),  0);
        check("per_abort_count", 32'(count), 0);

        // Pause at count 3, limit change ignored, resume, done 3 cycles later
        limit = 4'd5; presc = 4'd0; periodic = 0; start = 1;
        cyc(); start = 0;
        repeat (3) cyc();
        check("pz_count_c4", 32'(count), 3);
        stop = 1; limit = 4'd1;
        cyc(); stop = 0;
        for (int i = 0; i < 4; i++) begin
            check("pz_hold_count", 32'(count), 3);
            check("pz_hold_busy",  32'(busy),  1);
            if (i == 3) start = 1;
            cyc();
        end
        start = 0;
        check("pz_resume_count", 32'(count), 3);
        repeat (3) cyc();
        check("pz_done",      32'(done),  1);
        check("pz_done_busy", 32'(busy),  0);
        limit = 4'd0;

        // start+stop together in PAUSE aborts; stop in IDLE is ignored
        limit = 4'd7; start = 1;
        cyc(); start = 0;
        repeat (2) cyc();
        stop = 1; cyc();
        start = 1; cyc();
        start = 0; stop = 0;
        check("ss_busy",  32'(busy),  0);
        check("ss_count", 32'(count), 0);
        stop = 1; cyc(); stop = 0;
        check("idle_stop_busy", 32'(busy), 0);

        // Reset mid-run at count 2, then fresh start
        limit = 4'd5; presc = 4'd0; start = 1;
        cyc(); start = 0;
        repeat (2) cyc();
        check("mr_count2", 32'(count), 2);
        rst = 1; cyc(); rst = 0;
        check("mr_count", 32'(count), 0);
        check("mr_busy",  32'(busy),  0);
        check("mr_done",  32'(done),  0);
        check("mr_irq",   32'(irq),   0);
        limit = 4'd1; start = 1;
        cyc(); start = 0;
        cyc();
        check("mr_fresh_count", 32'(count), 1);
        cyc();
        check("mr_fresh_done", 32'(done), 1);

        // limit=0 presc=1 one-shot: done and irq at cycle 3, irq_clr clears
        limit = 4'd0; presc = 4'd1; periodic = 0; start = 1;
        cyc(); start = 0;
        check("irq_c1_done", 32'(done), 0);
        repeat (2) cyc();
        check("irq_c3_done", 32'(done), 1);
        check("irq_c3_irq",  32'(irq),  32'(c_irq_en));
        cyc();
        check("irq_c4_irq",  32'(irq),  32'(c_irq_en));
        irq_clr = 1; cyc(); irq_clr = 0;
        check("irq_cleared", 32'(irq), 0);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            start    = ($urandom_range(0, 3) == 0);
            stop     = ($urandom_range(0, 15) == 0);
            periodic = 1'($urandom_range(0, 1));
            limit    = 4'($urandom_range(0, 15));
            presc    = 4'($urandom_range(0, 3));
            irq_clr  = ($urandom_range(0, 7) == 0);
            cyc();
        end
        rst = 0; start = 0; stop = 0; irq_clr = 0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_interval_timer_ctrl
`default_nettype wire
